// File: rtl/pwm_pkg.sv
// Shared PWM definitions for the generator/decoder pair: state encoding and
// the nominal period/duty-code width both sides agree on.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } pwm_dec_state_t;

  localparam int PWM_PERIOD = 4;
  localparam int PWM_DUTY_W = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings pwm_in into the clk domain through two flops, then delays it once
// more so a single-cycle rising-edge indicator can be formed.
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic sync1;
  logic s_q;
  logic s_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s_q   <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s_q   <= sync1;
      s_d   <= s_q;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_d;

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and high time of an incoming PWM waveform between rising
// edges and reports the recovered duty code; constant levels end in STUCK.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter  int DUTY_W     = PWM_DUTY_W,
  parameter  int PERIOD     = PWM_PERIOD,
  parameter  int MAX_PERIOD = 15,
  localparam int CNT_W      = $clog2(MAX_PERIOD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  output logic [DUTY_W-1:0]    duty_cycle,
  output logic [CNT_W-1:0]     high_count,
  output logic [CNT_W-1:0]     period_count,
  output logic                 valid,
  output logic                 period_err,
  output logic                 timeout,
  output pwm_dec_state_t       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PERIOD);
  localparam int               DUTY_MAX = 2**DUTY_W - 1;

  // valid is a one-cycle strobe with no ready: the consumer must capture the
  // data outputs in the cycle valid is high; they then hold until the next one.

  logic           s;
  logic           rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  pwm_dec_state_t state, state_nx;
  logic           take_meas;
  logic           enter_stuck;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  // The rise cycle is itself high, so both counters restart at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
      if (s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    take_meas   = 1'b0;
    enter_stuck = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = MEASURE;
        end else if (per_cnt == CNT_MAX) begin
          state_nx    = STUCK;
          enter_stuck = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          take_meas = 1'b1;
        end else if (per_cnt == CNT_MAX) begin
          state_nx    = STUCK;
          enter_stuck = 1'b1;
        end
      end
      STUCK: begin
        if (rise) state_nx = MEASURE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_cycle   <= '0;
      high_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      period_err   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      valid <= take_meas | enter_stuck;
      if (take_meas) begin
        period_count <= per_cnt;
        high_count   <= hi_cnt;
        period_err   <= (per_cnt != CNT_W'(PERIOD));
        timeout      <= 1'b0;
        if (int'(hi_cnt) >= DUTY_MAX) duty_cycle <= '1;
        else                          duty_cycle <= hi_cnt[DUTY_W-1:0];
      end else if (enter_stuck) begin
        // Constant level: report it as 0% or 100% with no period.
        period_count <= '0;
        timeout      <= 1'b1;
        high_count   <= s ? CNT_MAX : '0;
        duty_cycle   <= s ? '1 : '0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: directed test-plan waveforms plus
// random periods, scored against a rise-to-rise measurement model.
module tb_pwm_decoder;
  import pwm_pkg::*;

  localparam int MAXP = 15;

  logic           clk;
  logic           reset;
  logic           pwm_in;
  logic [1:0]     duty_cycle;
  logic [3:0]     high_count;
  logic [3:0]     period_count;
  logic           valid;
  logic           period_err;
  logic           timeout;
  pwm_dec_state_t dbg_state;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .duty_cycle   (duty_cycle),
    .high_count   (high_count),
    .period_count (period_count),
    .valid        (valid),
    .period_err   (period_err),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected word: {timeout, period_err, duty[1:0], high[3:0], period[3:0]}
  logic [11:0] exp_q[$];
  logic [11:0] m_hold;
  bit          m_valid;
  bit          m_sync1, m_s, m_sd;
  int          m_age;   // cycles since the last rise (or since reset)
  int          m_hi;    // high cycles within that window
  int          m_mode;  // 0: no rise seen yet, 1: measuring, 2: timed out

  function automatic logic [11:0] mk(bit to, bit err, int duty, int hi, int per);
    logic [11:0] w;
    w = {to, err, 2'(duty), 4'(hi), 4'(per)};
    return w;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit r;
    int per, hi;
    logic [11:0] w;
    if (!reset) begin
      m_sync1 = 0; m_s = 0; m_sd = 0;
      m_age = 0; m_hi = 0; m_mode = 0;
      m_valid = 0; m_hold = '0;
      exp_q.delete();
    end else begin
      r = m_s && !m_sd;
      m_valid = 0;
      if (r) begin
        if (m_mode == 1) begin
          per = (m_age > MAXP) ? MAXP : m_age;
          hi  = (m_hi > MAXP) ? MAXP : m_hi;
          w = mk(0, per != PWM_PERIOD, (hi > 3) ? 3 : hi, hi, per);
          exp_q.push_back(w);
          m_hold = w;
          m_valid = 1;
        end
        m_mode = 1;
      end else if (m_mode != 2 && m_age >= MAXP) begin
        w = mk(1, m_hold[10], m_s ? 3 : 0, m_s ? MAXP : 0, 0);
        exp_q.push_back(w);
        m_hold = w;
        m_valid = 1;
        m_mode = 2;
      end
      m_age = r ? 1 : m_age + 1;
      m_hi  = r ? 1 : m_hi + int'(m_s);
      m_sd = m_s; m_s = m_sync1; m_sync1 = pwm_in;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    chk("valid", valid, m_valid);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("period_count", period_count, e[3:0]);
        chk("high_count", high_count, e[7:4]);
        chk("duty_cycle", duty_cycle, e[9:8]);
        chk("period_err", period_err, e[10]);
        chk("timeout", timeout, e[11]);
      end
    end else begin
      chk("hold", {timeout, period_err, duty_cycle, high_count, period_count}, m_hold);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_period(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      pwm_in = (i < hi);
    end
  endtask

  task automatic hold_level(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = lvl;
    end
  endtask

  // Asserts reset between clock edges and checks the outputs cleared at once.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_high", high_count, 0);
    chk("rst_period", period_count, 0);
    chk("rst_err", period_err, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int per, hi;
    n_checks = 0;
    n_fail   = 0;
    pwm_in   = 1'b0;
    reset    = 1'b1;
    pulse_reset();

    // Loop-back at duty 2, then switch to duty 1 and 3 mid-stream.
    repeat (6) send_period(4, 2);
    repeat (3) send_period(4, 1);
    repeat (3) send_period(4, 3);
    send_period(4, 2);

    // Held low from reset: one timeout strobe, then silence.
    pulse_reset();
    hold_level(0, 30);
    repeat (3) send_period(4, 2);

    // Held high after a rise, then normal periods clear timeout.
    hold_level(1, 20);
    repeat (3) send_period(4, 2);

    // Off-nominal period with saturated duty code.
    repeat (3) send_period(6, 5);

    // Reset mid-period, then resume.
    send_period(4, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    pulse_reset();
    repeat (4) send_period(4, 2);

    // Random periods, including ones long enough to time out.
    for (int k = 0; k < 60; k++) begin
      per = $urandom_range(2, 18);
      hi  = $urandom_range(1, per - 1);
      send_period(per, hi);
    end
    hold_level(0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart of the PWM generator: samples an incoming PWM waveform, measures each period and its high time in `clk` cycles, and reports the recovered duty-cycle code with a one-cycle valid strobe. Used for loop-back checking of the generator and for reading PWM-encoded sensor or control inputs on the board. A timeout path handles the constant-level waveforms that carry no rising edge, including the generator's duty 0.

## Interface
- `DUTY_W`, 2: width of the recovered duty code; matches the generator's `duty_cycle` input.
- `PERIOD`, 4: expected period in cycles; the generator counts 0..3.
- `MAX_PERIOD`, 15: cycle count without a rising edge that triggers a timeout; must be > `PERIOD`.
- `CNT_W`, `$clog2(MAX_PERIOD+1)`: width of the measurement counters; derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting low clears all state immediately.
- `pwm_in` in 1: PWM waveform, possibly asynchronous to `clk`.
- `duty_cycle` out DUTY_W: recovered duty code, `min(high_count, 2**DUTY_W-1)`.
- `high_count` out CNT_W: high cycles in the last complete period.
- `period_count` out CNT_W: length of the last complete period in cycles.
- `valid` out 1: one-cycle strobe; the outputs above were updated this cycle.
- `period_err` out 1: last measurement had `period_count != PERIOD`.
- `timeout` out 1: no rising edge for `MAX_PERIOD` cycles.

## Operation
- Input path: 2-flop synchronizer gives `s`. A third flop gives `s_d`. The rising-edge indicator is `rise = s & ~s_d`.
- Counters:
  - `per_cnt` counts cycles since the last rise.
  - `hi_cnt` counts cycles with `s = 1` since the last rise.
  - Both saturate at `MAX_PERIOD` and never wrap.
- On `rise`, both counters reload to 1, because the rise cycle is itself high.
- States:
  - `IDLE` (after reset): counts from 0.
    - `rise` moves to `MEASURE` with no `valid`; the first partial period is discarded.
    - `per_cnt == MAX_PERIOD` moves to `STUCK`.
  - `MEASURE`, on `rise`:
    - Register `period_count <= per_cnt` and `high_count <= hi_cnt`.
    - Update `duty_cycle`, set `period_err`, clear `timeout`, pulse `valid`.
    - Reload the counters and stay in `MEASURE`.
  - `MEASURE`, on `per_cnt == MAX_PERIOD` without `rise`: go to `STUCK`.
  - Entering `STUCK` (a single-cycle action):
    - Pulse `valid` and set `timeout`.
    - `period_count <= 0`.
    - If `s = 1`: `high_count <= MAX_PERIOD` and `duty_cycle <=` all-ones. If `s = 0`: both 0.
  - In `STUCK`: outputs hold. `rise` reloads the counters and goes to `MEASURE`; `timeout` stays 1 until the next `MEASURE` update.
- Simultaneous `rise` and counter at `MAX_PERIOD`: `rise` wins and the measurement is a normal one, with `period_count = MAX_PERIOD` and `period_err = 1`.
- Reset mid-period: state returns to `IDLE`, partial counts are lost, and no `valid` is produced.

## Timing
- Reset values:
  - All outputs 0.
  - Synchronizer flops and `s_d` 0.
  - Counters 0, state `IDLE`.
- Latency: `pwm_in` first sampled high at edge k gives `s = 1` after edge k+1. `rise` is asserted during the following cycle, and outputs plus `valid` appear after edge k+2.
- `valid` is high for exactly one cycle per completed period or timeout entry. The gap between strobes is at least 2 cycles.
- Data outputs change only in a `valid` cycle and are stable otherwise.
- Minimum measurable period: 2 cycles. Pulses shorter than one `clk` cycle may be missed; this is by design.

## Structure
- Package `pwm_pkg`:
  - `typedef enum logic [1:0] {IDLE, MEASURE, STUCK} pwm_dec_state_t`
  - Constants `PWM_PERIOD = 4` and `PWM_DUTY_W = 2`, shared with the generator.
- Sub-module `pwm_edge_sync`: 2-flop synchronizer plus delay flop. Outputs `s` and `rise`, with the same asynchronous active-low `reset`.
- Top level: FSM, two saturating counters, output registers.

## Test plan
- Generator loop-back, `duty_cycle = 2`, period 4 (`1100` repeating):
  - No `valid` on the first period.
  - Then `valid` every 4 cycles with `high_count = 2`, `period_count = 4`, `duty_cycle = 2`, `period_err = 0`.
- Sweep duty 1 → 3 mid-stream:
  - Next full periods report `high_count` 1, then 3.
  - `duty_cycle` follows. No spurious `valid` at the switch.
- `pwm_in` held 0 (generator duty 0) from reset:
  - After 15 idle cycles, one `valid` with `timeout = 1`, `duty_cycle = 0`, `period_count = 0`.
  - No further `valid` until a rise.
- `pwm_in` held 1 for 20 cycles after a rise:
  - `valid` with `timeout = 1`, `high_count = 15`, `duty_cycle = 3`.
  - On the next proper period, `timeout` clears.
- Period 6, high 5:
  - `period_count = 6`, `high_count = 5`, `duty_cycle = 3` (saturated), `period_err = 1`.
- Assert `reset` low mid-period:
  - Outputs 0 immediately, without waiting for a clock edge.
  - After release, the first partial period is discarded and `valid` resumes one period later.
